// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs decoded instruction fields (cond, op, funct, rn, rd, imm) into
//   32-bit ARM machine words. It writes them one after another into
//   instruction memory, starting at a session base address. The test and
//   boot path use it to build programs without a hand-assembled hex file.
//
// Optional feature macro: INSTR_CHECKSUM_EN
//   defined   -> checksum is a running XOR of every word written this session
//   undefined -> checksum is tied to 0 and no XOR register is built
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, base_addr    one-cycle session start pulse and first word address
//   finish              ends the session (taken only while accepting)
//   in_valid/in_ready   field bundle handshake
//   cond/op/funct/rn/rd/imm  decoded fields (imm = Src2[11:0] or Imm24)
//   imem_we/addr/wdata  instruction memory write port
//   word_count          words written this session
//   done                one-cycle session-complete pulse
//   full                session stopped at the last address (DEPTH-1)
//   err                 sticky: an op=11 bundle was rejected
//   checksum            XOR of the words written (see macro above)
module instr_encoder_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        cond,
    input  logic [1:0]        op,
    input  logic [5:0]        funct,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic [23:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [31:0]       checksum
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              fin_pend;   // finish seen together with a legal accept
    logic              accept;
    logic              legal;
    logic [31:0]       enc_word;

    // These strobes are decoded from the state. A reset therefore drops
    // them at once, even in the middle of a write.
    assign in_ready  = (state == S_ACCEPT);
    assign imem_we   = (state == S_WRITE);
    assign done      = (state == S_DONE);
    assign imem_addr = ptr;

    assign accept = in_valid & in_ready;
    assign legal  = (op != 2'b11);

    // Branches keep only funct[5:4] (the link/offset bits) and take the
    // full 24-bit immediate. DP and memory words carry every field.
    always_comb begin
        if (op == 2'b10)
            enc_word = {cond, 2'b10, funct[5:4], imm};
        else
            enc_word = {cond, op, funct, rn, rd, imm[11:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            fin_pend   <= 1'b0;
            imem_wdata <= '0;
            word_count <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr        <= base_addr;
                        word_count <= '0;
                        full       <= 1'b0;
                        err        <= 1'b0;
                        fin_pend   <= 1'b0;
                        state      <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (accept && legal) begin
                        imem_wdata <= enc_word;
                        fin_pend   <= finish;
                        state      <= S_WRITE;
                    end else begin
                        // An illegal bundle is consumed and dropped.
                        if (accept)
                            err <= 1'b1;
                        if (finish)
                            state <= S_DONE;
                    end
                end
                S_WRITE: begin
                    word_count <= word_count + (ADDR_W+1)'(1);
                    if (ptr == LAST_ADDR) begin
                        // The pointer does not wrap, so the session ends here.
                        full  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        ptr   <= ptr + ADDR_W'(1);
                        state <= fin_pend ? S_DONE : S_ACCEPT;
                    end
                end
                default: begin
                    fin_pend <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            checksum <= '0;
        else if (state == S_IDLE && start)
            checksum <= '0;
        else if (state == S_WRITE)
            checksum <= checksum ^ imem_wdata;
    end
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader. The reference
// model tracks each session as plain numbers: the write pointer, the word
// count, the flags and the XOR of the words. It builds every expected word
// with arithmetic on the field values.
module tb_instr_encoder_loader;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
`ifdef INSTR_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, finish = 1'b0, in_valid = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [3:0] cond = '0, rn = '0, rd = '0;
    logic [1:0] op = '0;
    logic [5:0] funct = '0;
    logic [23:0] imm = '0;
    logic in_ready, imem_we, done, full, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0] imem_wdata, checksum;
    logic [ADDR_W:0] word_count;

    int n_cmp = 0, n_bad = 0;
    int m_ptr = 0, m_wc = 0;
    bit m_full = 0, m_err = 0, m_active = 0;
    logic [31:0] m_cks = '0;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .op(op), .funct(funct), .rn(rn), .rd(rd), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .done(done), .full(full), .err(err),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ARM word from its fields, built as a sum of shifted fields.
    function automatic logic [31:0] ref_enc(input int c, input int o, input int f,
                                            input int n, input int d, input int im);
        longint w;
        if (o == 2)
            w = 64'(c) * 64'd268435456 + 64'd2 * 64'd67108864
              + 64'(f / 16) * 64'd16777216 + 64'(im % 16777216);
        else
            w = 64'(c) * 64'd268435456 + 64'(o) * 64'd67108864 + 64'(f) * 64'd1048576
              + 64'(n) * 64'd65536 + 64'(d) * 64'd4096 + 64'(im % 4096);
        return w[31:0];
    endfunction

    task automatic chk_stat(input string t);
        chk({t, "_wc"}, word_count, m_wc);
        chk({t, "_full"}, full, m_full);
        chk({t, "_err"}, err, m_err);
        chk({t, "_cks"}, checksum, CK_EN ? m_cks : 32'h0);
    endtask

    // Called at the negedge where done should be high.
    task automatic end_tail(input string t);
        chk({t, "_done"}, done, 1);
        @(negedge clk);
        chk({t, "_done_pulse"}, done, 0);
        chk({t, "_idle_rdy"}, in_ready, 0);
        chk_stat(t);
        m_active = 0;
    endtask

    task automatic do_start(input int b);
        base_addr = ADDR_W'(b); start = 1;
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        m_ptr = b; m_wc = 0; m_full = 0; m_err = 0; m_cks = '0; m_active = 1;
        chk("start_rdy", in_ready, 1);
        chk("start_addr", imem_addr, b);
        chk_stat("start");
    endtask

    task automatic do_finish();
        finish = 1;
        @(posedge clk); #1 finish = 0;
        @(negedge clk);
        chk("fin_we", imem_we, 0);
        end_tail("fin");
    endtask

    // Offers one bundle while in ACCEPT. The caller keeps fin=0 for op 3.
    task automatic do_bundle(input int c, input int o, input int f, input int n,
                             input int d, input int im, input bit fin);
        logic [31:0] w;
        bit last;
        chk("acc_rdy", in_ready, 1);
        cond = 4'(c); op = 2'(o); funct = 6'(f); rn = 4'(n); rd = 4'(d); imm = 24'(im);
        in_valid = 1; finish = fin;
        @(posedge clk); #1 in_valid = 0; finish = 0;
        @(negedge clk);
        if (o == 3) begin
            m_err = 1;
            chk("ill_we", imem_we, 0);
            chk("ill_err", err, 1);
            chk("ill_rdy", in_ready, 1);
            chk("ill_wc", word_count, m_wc);
        end else begin
            w = ref_enc(c, o, f, n, d, im);
            chk("wr_we", imem_we, 1);
            chk("wr_addr", imem_addr, m_ptr);
            chk("wr_data", imem_wdata, w);
            chk("wr_rdy", in_ready, 0);
            m_cks ^= w; m_wc++;
            last = (m_ptr == DEPTH - 1);
            if (last) m_full = 1; else m_ptr++;
            @(negedge clk);
            chk("wr_we_off", imem_we, 0);
            chk("wr_wc", word_count, m_wc);
            if (last || fin) end_tail("wr");
            else chk("wr_back", in_ready, 1);
        end
    endtask

    initial begin
        #2;
        chk("rst_rdy", in_ready, 0); chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0); chk("rst_wdata", imem_wdata, 0);
        chk("rst_done", done, 0);
        chk_stat("rst");
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Single DP word
        do_start(0);
        do_bundle(14, 0, 6'b101000, 2, 1, 5, 0);
        chk("dp_word", imem_wdata, 32'hE2821005);
        do_finish();
        chk("dp_wc", word_count, 1);

        // LDR then branch, with finish sent together with the branch
        do_start(0);
        do_bundle(14, 1, 6'b011001, 4, 3, 8, 0);
        chk("ldr_word", imem_wdata, 32'hE5943008);
        do_bundle(14, 2, 6'b100110, 9, 7, 2, 1);
        chk("b_word", imem_wdata, 32'hEA000002);
        chk("b_wc", word_count, 2);
        chk("b_cks", checksum, CK_EN ? 32'h0F94300A : 32'h0);

        // Illegal op, a start that must be ignored, then a legal write
        do_start(10);
        do_bundle(14, 3, 6'h3F, 1, 1, 1, 0);
        base_addr = 6'd40; start = 1;
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        chk("ign_start_addr", imem_addr, 10);
        chk("ign_start_rdy", in_ready, 1);
        do_bundle(14, 0, 6'b000100, 3, 3, 12'h0FF, 0);
        do_finish();

        // Address limit: the third bundle must never be accepted
        do_start(62);
        do_bundle(1, 0, 5, 6, 7, 8, 0);
        do_bundle(2, 1, 9, 10, 11, 12, 0);
        chk("lim_full", full, 1);
        in_valid = 1; op = 2'd0;
        repeat (3) begin
            @(negedge clk);
            chk("lim_rdy", in_ready, 0);
            chk("lim_we", imem_we, 0);
        end
        in_valid = 0;
        chk("lim_wc", word_count, 2);

        // Reset in the middle of a write
        do_start(20);
        cond = 4'hE; op = 2'd0; in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
        @(negedge clk);
        chk("rw_we", imem_we, 1);
        #2 rst_n = 0;
        #1;
        m_wc = 0; m_full = 0; m_err = 0; m_cks = '0; m_active = 0;
        chk("rw_we_drop", imem_we, 0); chk("rw_rdy", in_ready, 0);
        chk("rw_addr", imem_addr, 0); chk("rw_wdata", imem_wdata, 0);
        chk("rw_done", done, 0);
        chk_stat("rw");
        @(negedge clk);
        rst_n = 1;
        in_valid = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rw_no_acc", in_ready, 0);
            chk("rw_no_we", imem_we, 0);
        end
        in_valid = 0;

        // Randomized sessions
        for (int s = 0; s < 40; s++) begin
            int nb;
            do_start($urandom_range(0, DEPTH - 1));
            nb = $urandom_range(1, 6);
            for (int k = 0; k < nb && m_active; k++) begin
                int o;
                bit fin;
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    chk("gap_rdy", in_ready, 1);
                end
                o = ($urandom_range(0, 5) == 0) ? 3 : $urandom_range(0, 2);
                fin = (k == nb - 1) && (o != 3) && ($urandom_range(0, 1) == 1);
                do_bundle($urandom_range(0, 15), o, $urandom_range(0, 63),
                          $urandom_range(0, 15), $urandom_range(0, 15),
                          $urandom_range(0, 24'hFFFFFF), fin);
            end
            if (m_active) do_finish();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Producer side of the instruction word that the control decoder consumes.
- Accepts decoded fields (cond, Op, Funct, Rn, Rd, Src2/Imm24) over a valid/ready handshake and packs them into 32-bit ARM machine words.
- Writes the words sequentially into instruction memory through a write port.
- Used by the test/boot path to build programs in instruction memory without a hand-assembled hex file.

Parameters:
- ADDR_W, 6, word-address width of the instruction memory write port.
- DEPTH, 64, number of writable words; the last valid address is DEPTH-1 (DEPTH <= 2**ADDR_W).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load session at base_addr.
- base_addr  input  ADDR_W  first word address of the session.
- finish  input  1  ends the session.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- cond  input  4  condition field.
- op  input  2  Op field.
- funct  input  6  Funct field.
- rn  input  4  Rn field.
- rd  input  4  Rd field.
- imm  input  24  Src2 in [11:0] for DP/memory; Imm24 for branch.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  ADDR_W  write word address.
- imem_wdata  output  32  encoded instruction.
- word_count  output  ADDR_W+1  words written this session.
- done  output  1  one-cycle session-complete pulse.
- full  output  1  session stopped at address DEPTH-1.
- err  output  1  sticky; an illegal bundle was rejected.
- checksum  output  32  running XOR of written words (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - All outputs go to 0: in_ready, imem_we, imem_addr, imem_wdata, word_count, done, full, err, checksum.
  - A reset mid-write aborts that write. A write strobe that is already high drops immediately.
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - On start=1: load the address pointer with base_addr, clear word_count, full, err and checksum, then go to ACCEPT.
  - start is ignored in every other state.
- ACCEPT:
  - in_ready=1.
  - A bundle is accepted when in_valid and in_ready are both 1.
  - Encoding for op 00 or 01: {cond, op, funct, rn, rd, imm[11:0]}.
  - Encoding for op 10: {cond, 2'b10, funct[5:4], imm[23:0]}. funct[3:0], rn and rd are ignored.
  - The encoded word is registered into imem_wdata; next state is WRITE.
  - op 11 is illegal: the bundle is consumed, nothing is written, err sets, and the state stays ACCEPT.
  - finish=1 with no accepted bundle: go to DONE.
  - finish=1 in the same cycle as a legal accept: the instruction is written first, then the block goes to DONE.
- WRITE:
  - in_ready=0, imem_we=1 for exactly one cycle; imem_addr holds the pointer value.
  - On exit: word_count increments by 1.
  - If the pointer equals DEPTH-1: set full and go to DONE. The pointer does not wrap.
  - Otherwise: the pointer increments; go to DONE if a finish was latched, else return to ACCEPT.
- DONE:
  - done=1 for one cycle, then return to IDLE.
  - word_count, full, err and checksum hold their values until the next start.
- Timing:
  - Accept-to-write latency is 1 cycle: a bundle accepted at edge N gives imem_we=1 in the cycle after N.
  - Throughput is one instruction per 2 cycles.
- While in ACCEPT, finish is sampled only when it is 1; a pending finish is latched into a one-bit flag.

Optional Feature:
- Macro: INSTR_CHECKSUM_EN.
- Defined: on each WRITE cycle, checksum <= checksum ^ imem_wdata. It is cleared on start and on reset.
- Undefined: checksum is tied to 32'h0 and no XOR register is synthesised.

Test Plan:
- Single DP bundle. Stimulus: reset, start with base_addr=0, then cond=E, op=00, funct=101000, rn=2, rd=1, imm=0x005. Required: imem_we=1 one cycle after accept, imem_addr=0, imem_wdata=0xE2821005, word_count=1.
- Memory and branch back-to-back:
  - LDR bundle: cond=E, op=01, funct=011001, rn=4, rd=3, imm=0x008. Required: word 0xE5943008 at address 0.
  - B bundle: op=10, funct=10xxxx, imm=0x000002. Required: word 0xEA000002 at address 1.
  - Required session result: word_count=2. With INSTR_CHECKSUM_EN defined, checksum=0x0F94300A.
- Illegal op. Stimulus: op=11 bundle. Required: err=1, imem_we stays 0, word_count unchanged; the next legal bundle still writes to the same address.
- Finish handling:
  - finish together with a legal accept. Required: the word is written, then done pulses one cycle, then the state is IDLE.
  - finish alone in ACCEPT. Required: done pulses with no write.
- Address limit. Stimulus: base_addr=62, DEPTH=64, then 3 bundles. Required: writes at addresses 62 and 63, full=1, done pulses, the third bundle is never accepted (in_ready=0), word_count=2.
- Reset during WRITE. Stimulus: deassert rst_n while imem_we=1. Required: imem_we drops immediately, all outputs read 0, and a new start is needed before any further accept.
